game_io_regbank: RTL and testbench
==================================

GAME_IO_REGBANK -- requirements
Module: game_io_regbank

Interface
REQ-001 Parameter DATA_W, 32, register and data width.
REQ-002 Parameter NUM_REGS, 32, architectural register count; AW = clog2(NUM_REGS).
REQ-003 Parameter N_IN, 3, number of external input channels; range 1..8.
REQ-004 Parameter N_OUT, 1, number of external output registers; range 1..4.
REQ-005 Parameter IN_BASE, 1, register index of input channel 0; legal only if IN_BASE >= 1 and IN_BASE+N_IN+N_OUT <= NUM_REGS.
REQ-006 Derived OUT_BASE = IN_BASE+N_IN, register index of output channel 0.
REQ-007 clock  input  1  single system clock; all state on rising edge.
REQ-008 reset  input  1  asynchronous, active-high reset.
REQ-009 clk_en  input  1  processor tick; architectural writes take effect only on edges where clk_en=1.
REQ-010 ctrl_writeEnable  input  1  write strobe.
REQ-011 ctrl_writeReg  input  AW  write index.
REQ-012 ctrl_readRegA, ctrl_readRegB  input  AW each  read indices.
REQ-013 data_writeReg  input  DATA_W  write data.
REQ-014 data_readRegA, data_readRegB  output  DATA_W each  read data.
REQ-015 ext_in  input  N_IN  asynchronous external levels (e.g. move_left, move_right, game_status).
REQ-016 ext_out  output  N_OUT*DATA_W  output register contents, channel k at bits [k*DATA_W +: DATA_W] (channel 0 = spaceship_x).
REQ-017 ext_out_valid  output  N_OUT  one-clock update pulse per output channel.

Function
REQ-018 Reads SHALL be combinational from current state; no write-to-read bypass (written value visible after the write edge).
REQ-019 Register 0 and indices >= NUM_REGS SHALL read zero and ignore writes.
REQ-020 A write SHALL occur when clk_en=1 and ctrl_writeEnable=1 on a rising clock edge; otherwise state holds.
REQ-021 General registers (not in input or output windows) SHALL store data_writeReg on a write.
REQ-022 Each ext_in bit SHALL pass through a two-flop synchronizer clocked every edge, independent of clk_en; sync latency 2 clocks.
REQ-023 A rising edge of the synchronized level SHALL set that channel's sticky flag on the next clock, independent of clk_en.
REQ-024 Input register IN_BASE+i SHALL read: bit0 = synchronized level, bit1 = sticky flag, all other bits zero.
REQ-025 Write to an input register SHALL clear the sticky flag iff data_writeReg bit1 = 1 (write-1-to-clear); bit0 and other bits ignored.
REQ-026 Simultaneous sticky set and W1C clear on the same edge: set SHALL win (flag remains 1).
REQ-027 Output register OUT_BASE+k SHALL store data_writeReg on a write and drive ext_out channel k continuously.
REQ-028 ext_out_valid[k] SHALL be 1 for exactly the one clock following each write to channel k, including writes of an unchanged value.
REQ-029 Back-to-back writes on consecutive enabled edges SHALL yield consecutive valid pulses (held high).

Reset
REQ-030 While reset=1, all registers, output registers, synchronizer flops, sticky flags and ext_out_valid SHALL be zero, asynchronously.
REQ-031 Reset asserted mid-operation SHALL discard pending edges and flags; after deassertion an input already high SHALL NOT set a sticky flag until it falls and rises again.

Structure
REQ-032 Shared package game_io_pkg SHALL hold default parameter values, LEVEL_BIT=0, EDGE_BIT=1 field positions, and address-map helper constants.
REQ-033 Per-channel synchronizer plus edge latch SHALL be sub-module in_sync_edge, instantiated N_IN times via generate.

Verification
REQ-034 Reset then write 0x1234 to reg 5 with clk_en=1 -> readRegA=5 returns 0x00001234 after edge; same write with clk_en=0 -> reads 0.
REQ-035 Write 0xFFFFFFFF to reg 0 -> readRegA=0 and readRegB=0 return 0.
REQ-036 Raise ext_in[0] -> reg 1 reads 0x0 for 2 clocks, then 0x3 on the 3rd; write 0x2 to reg 1 -> reads 0x1.
REQ-037 Defaults, write 0x00000140 to reg 4 -> ext_out=0x140 from next edge, ext_out_valid[0]=1 for one clock only.
REQ-038 New ext_in[1] rising edge coincident with W1C write to reg 2 -> reg 2 still reads 0x3.
REQ-039 Assert reset mid-run with ext_in=3'b111 held -> all reads 0; after release input regs read 0x1, never 0x3.

Source files
------------

// File: rtl/game_io_pkg.sv
// rtl/game_io_pkg.sv - shared defaults, field positions and address-map helpers for game_io_regbank
package game_io_pkg;
   localparam int DEF_DATA_W   = 32;
   localparam int DEF_NUM_REGS = 32;
   localparam int DEF_N_IN     = 3;
   localparam int DEF_N_OUT    = 1;
   localparam int DEF_IN_BASE  = 1;

   localparam int LEVEL_BIT = 0;
   localparam int EDGE_BIT  = 1;

   typedef enum logic [1:0] {
      REG_ZERO,
      REG_GEN,
      REG_IN,
      REG_OUT
   } region_e;

   function automatic region_e reg_region(input int idx, input int num_regs, input int in_base,
                                          input int n_in, input int n_out);
      if (idx == 0 || idx >= num_regs) return REG_ZERO;
      if (idx >= in_base && idx < in_base + n_in) return REG_IN;
      if (idx >= in_base + n_in && idx < in_base + n_in + n_out) return REG_OUT;
      return REG_GEN;
   endfunction
endpackage

// File: rtl/in_sync_edge.sv
// rtl/in_sync_edge.sv - two-flop synchronizer with sticky rising-edge flag and write-1-to-clear
module in_sync_edge (
   input  logic clock,
   input  logic reset,
   input  logic async_i,
   input  logic clr_i,
   output logic level_o,
   output logic sticky_o
);
   logic meta_q, sync_q, seen_q, armed_q, sticky_q;
   logic armed_d, sticky_d, rise;

   // An edge only counts once a genuine low has been sampled after reset,
   // so an input already high at reset release never raises the flag.
   always_comb begin
      rise     = armed_q & meta_q & ~sync_q;
      armed_d  = armed_q | (seen_q & ~meta_q);
      sticky_d = rise | (sticky_q & ~clr_i);
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         meta_q   <= 1'b0;
         sync_q   <= 1'b0;
         seen_q   <= 1'b0;
         armed_q  <= 1'b0;
         sticky_q <= 1'b0;
      end else begin
         meta_q   <= async_i;
         sync_q   <= meta_q;
         seen_q   <= 1'b1;
         armed_q  <= armed_d;
         sticky_q <= sticky_d;
      end
   end

   assign level_o  = sync_q;
   assign sticky_o = sticky_q;
endmodule

// File: rtl/game_io_regbank.sv
// rtl/game_io_regbank.sv - processor register file with memory-mapped input flags and output registers
module game_io_regbank
   import game_io_pkg::*;
#(
   parameter int DATA_W   = DEF_DATA_W,
   parameter int NUM_REGS = DEF_NUM_REGS,
   parameter int N_IN     = DEF_N_IN,
   parameter int N_OUT    = DEF_N_OUT,
   parameter int IN_BASE  = DEF_IN_BASE,
   localparam int AW      = $clog2(NUM_REGS)
) (
   input  logic                    clock,
   input  logic                    reset,
   input  logic                    clk_en,
   input  logic                    ctrl_writeEnable,
   input  logic [AW-1:0]           ctrl_writeReg,
   input  logic [AW-1:0]           ctrl_readRegA,
   input  logic [AW-1:0]           ctrl_readRegB,
   input  logic [DATA_W-1:0]       data_writeReg,
   output logic [DATA_W-1:0]       data_readRegA,
   output logic [DATA_W-1:0]       data_readRegB,
   input  logic [N_IN-1:0]         ext_in,
   output logic [N_OUT*DATA_W-1:0] ext_out,
   output logic [N_OUT-1:0]        ext_out_valid
);
   localparam int OUT_BASE = IN_BASE + N_IN;

   logic                    wr_en;
   region_e                 wr_region;
   logic [DATA_W-1:0]       gen_q [NUM_REGS];
   logic [N_OUT*DATA_W-1:0] out_q;
   logic [N_OUT-1:0]        valid_q, valid_d;
   logic [N_IN-1:0]         level, sticky, clr;

   assign wr_en     = clk_en & ctrl_writeEnable;
   assign wr_region = reg_region(int'(ctrl_writeReg), NUM_REGS, IN_BASE, N_IN, N_OUT);

   for (genvar i = 0; i < N_IN; i++) begin : g_in
      assign clr[i] = wr_en && (int'(ctrl_writeReg) == IN_BASE + i) && data_writeReg[EDGE_BIT];
      in_sync_edge u_sync (
         .clock    (clock),
         .reset    (reset),
         .async_i  (ext_in[i]),
         .clr_i    (clr[i]),
         .level_o  (level[i]),
         .sticky_o (sticky[i])
      );
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         for (int r = 0; r < NUM_REGS; r++) gen_q[r] <= '0;
      end else if (wr_en && wr_region == REG_GEN) begin
         gen_q[ctrl_writeReg] <= data_writeReg;
      end
   end

   // valid_d doubles as the write strobe, so the pulse tracks every write, changed value or not.
   for (genvar k = 0; k < N_OUT; k++) begin : g_out
      assign valid_d[k] = wr_en && (int'(ctrl_writeReg) == OUT_BASE + k);
      always_ff @(posedge clock or posedge reset) begin
         if (reset) begin
            out_q[k*DATA_W +: DATA_W] <= '0;
            valid_q[k]                <= 1'b0;
         end else begin
            valid_q[k] <= valid_d[k];
            if (valid_d[k]) out_q[k*DATA_W +: DATA_W] <= data_writeReg;
         end
      end
   end

   function automatic logic [DATA_W-1:0] read_reg(input logic [AW-1:0] idx);
      logic [DATA_W-1:0] v;
      logic [N_IN-1:0]   in_sel;
      v      = '0;
      in_sel = '0;
      case (reg_region(int'(idx), NUM_REGS, IN_BASE, N_IN, N_OUT))
         REG_GEN: v = gen_q[idx];
         REG_IN: begin
            in_sel       = N_IN'(1) << (int'(idx) - IN_BASE);
            v[LEVEL_BIT] = |(level & in_sel);
            v[EDGE_BIT]  = |(sticky & in_sel);
         end
         REG_OUT: v = DATA_W'(out_q >> (DATA_W * (int'(idx) - OUT_BASE)));
         default: v = '0;
      endcase
      return v;
   endfunction

   assign data_readRegA = read_reg(ctrl_readRegA);
   assign data_readRegB = read_reg(ctrl_readRegB);
   assign ext_out       = out_q;
   assign ext_out_valid = valid_q;
endmodule

// File: tb/tb_game_io_regbank.sv
// tb/tb_game_io_regbank.sv - self-checking bench for game_io_regbank
module tb_game_io_regbank;
   logic        clock = 1'b0;
   logic        reset;
   logic        clk_en;
   logic        ctrl_writeEnable;
   logic [4:0]  ctrl_writeReg, ctrl_readRegA, ctrl_readRegB;
   logic [31:0] data_writeReg, data_readRegA, data_readRegB;
   logic [2:0]  ext_in;
   logic [31:0] ext_out;
   logic [0:0]  ext_out_valid;

   int total = 0;
   int bad   = 0;

   logic [31:0] m_gen [32];
   logic [31:0] m_out;
   logic        m_valid;
   logic [2:0]  m_level, m_sticky;
   logic [2:0]  samp[$];

   game_io_regbank dut (
      .clock            (clock),
      .reset            (reset),
      .clk_en           (clk_en),
      .ctrl_writeEnable (ctrl_writeEnable),
      .ctrl_writeReg    (ctrl_writeReg),
      .ctrl_readRegA    (ctrl_readRegA),
      .ctrl_readRegB    (ctrl_readRegB),
      .data_writeReg    (data_writeReg),
      .data_readRegA    (data_readRegA),
      .data_readRegB    (data_readRegB),
      .ext_in           (ext_in),
      .ext_out          (ext_out),
      .ext_out_valid    (ext_out_valid)
   );

   always #5 clock = ~clock;

   initial begin
      #400000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      for (int r = 0; r < 32; r++) m_gen[r] = '0;
      m_out    = '0;
      m_valid  = 1'b0;
      m_level  = '0;
      m_sticky = '0;
      samp.delete();
   endtask

   // Synchronized level is the input sampled two edges ago; an edge counts only
   // when the sample before it was a real post-reset low.
   task automatic model_edge();
      logic [2:0] cur, prev;
      logic       clr;
      int         t;
      samp.push_back(ext_in);
      t    = samp.size();
      cur  = (t >= 2) ? samp[t-2] : 3'b000;
      prev = (t >= 3) ? samp[t-3] : 3'b111;
      for (int i = 0; i < 3; i++) begin
         clr = clk_en && ctrl_writeEnable && (int'(ctrl_writeReg) == i + 1) && data_writeReg[1];
         m_sticky[i] = (cur[i] && !prev[i]) || (m_sticky[i] && !clr);
      end
      m_level = cur;
      m_valid = 1'b0;
      if (clk_en && ctrl_writeEnable) begin
         if (ctrl_writeReg == 5'd4) begin
            m_out   = data_writeReg;
            m_valid = 1'b1;
         end else if (ctrl_writeReg >= 5'd5) begin
            m_gen[ctrl_writeReg] = data_writeReg;
         end
      end
   endtask

   function automatic logic [31:0] exp_read(input logic [4:0] idx);
      if (idx == 5'd0) return 32'h0;
      if (idx >= 5'd1 && idx <= 5'd3) return {30'b0, m_sticky[idx-5'd1], m_level[idx-5'd1]};
      if (idx == 5'd4) return m_out;
      return m_gen[idx];
   endfunction

   task automatic tick();
      @(posedge clock);
      model_edge();
      #1;
      check("ext_out", ext_out, m_out);
      check("ext_out_valid", {31'b0, ext_out_valid}, {31'b0, m_valid});
   endtask

   task automatic drive(input logic en, input logic we, input logic [4:0] wr, input logic [31:0] wd);
      clk_en           = en;
      ctrl_writeEnable = we;
      ctrl_writeReg    = wr;
      data_writeReg    = wd;
   endtask

   task automatic check_pair(input string tag, input logic [4:0] a, input logic [4:0] b);
      ctrl_readRegA = a;
      ctrl_readRegB = b;
      #1;
      check({tag, "_A"}, data_readRegA, exp_read(a));
      check({tag, "_B"}, data_readRegB, exp_read(b));
   endtask

   task automatic check_a(input string tag, input logic [4:0] a, input logic [31:0] exp);
      ctrl_readRegA = a;
      #1;
      check(tag, data_readRegA, exp);
   endtask

   initial begin
      reset = 1'b1;
      ext_in = 3'b000;
      ctrl_readRegA = 5'd0;
      ctrl_readRegB = 5'd0;
      drive(1'b0, 1'b0, 5'd0, 32'h0);
      model_reset();
      #2;
      check_pair("reset_rd", 5'd5, 5'd1);
      check("reset_out", ext_out, 32'h0);
      check("reset_valid", {31'b0, ext_out_valid}, 32'h0);
      @(posedge clock);
      @(posedge clock);
      #1 reset = 1'b0;
      repeat (4) tick();

      drive(1'b1, 1'b1, 5'd5, 32'h1234);
      tick();
      drive(1'b1, 1'b0, 5'd0, 32'h0);
      check_a("wr_en_r5", 5'd5, 32'h0000_1234);
      drive(1'b0, 1'b1, 5'd6, 32'h1234);
      tick();
      drive(1'b1, 1'b0, 5'd0, 32'h0);
      check_a("wr_noen_r6", 5'd6, 32'h0);

      drive(1'b1, 1'b1, 5'd0, 32'hFFFF_FFFF);
      tick();
      drive(1'b1, 1'b0, 5'd0, 32'h0);
      ctrl_readRegB = 5'd0;
      check_a("r0_A", 5'd0, 32'h0);
      check("r0_B", data_readRegB, 32'h0);

      ext_in = 3'b001;
      check_a("in0_pre", 5'd1, 32'h0);
      tick();
      check_a("in0_e1", 5'd1, 32'h0);
      tick();
      check_a("in0_e2", 5'd1, 32'h3);
      drive(1'b1, 1'b1, 5'd1, 32'h2);
      tick();
      drive(1'b1, 1'b0, 5'd0, 32'h0);
      check_a("in0_w1c", 5'd1, 32'h1);

      drive(1'b1, 1'b1, 5'd4, 32'h140);
      tick();
      check("out_val", ext_out, 32'h140);
      check("out_pulse", {31'b0, ext_out_valid}, 32'h1);
      drive(1'b1, 1'b0, 5'd0, 32'h0);
      tick();
      check("out_pulse_end", {31'b0, ext_out_valid}, 32'h0);
      drive(1'b1, 1'b1, 5'd4, 32'h140);
      tick();
      tick();
      check("out_b2b", {31'b0, ext_out_valid}, 32'h1);
      drive(1'b1, 1'b0, 5'd0, 32'h0);
      tick();

      ext_in = 3'b011;
      tick();
      drive(1'b1, 1'b1, 5'd2, 32'h2);
      tick();
      drive(1'b1, 1'b0, 5'd0, 32'h0);
      check_a("set_wins", 5'd2, 32'h3);

      for (int n = 0; n < 300; n++) begin
         drive(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)),
               5'($urandom_range(0, 31)), $urandom);
         if ($urandom_range(0, 5) == 0) ext_in = 3'($urandom);
         tick();
         check_pair("rand", 5'($urandom_range(0, 31)), 5'($urandom_range(0, 7)));
      end

      drive(1'b1, 1'b0, 5'd0, 32'h0);
      ext_in = 3'b111;
      repeat (3) tick();
      reset = 1'b1;
      model_reset();
      #1;
      check_pair("mid_rst_a", 5'd1, 5'd2);
      check_pair("mid_rst_b", 5'd3, 5'd4);
      check("mid_rst_out", ext_out, 32'h0);
      check("mid_rst_valid", {31'b0, ext_out_valid}, 32'h0);
      @(posedge clock);
      @(posedge clock);
      #1 reset = 1'b0;
      for (int n = 0; n < 6; n++) begin
         tick();
         check_pair("post_rst", 5'd1, 5'd2);
         ctrl_readRegA = 5'd3;
         #1;
         check("no_sticky", data_readRegA & 32'h2, 32'h0);
      end
      check_a("post_rst_lvl", 5'd1, 32'h1);

      ext_in = 3'b110;
      repeat (3) tick();
      ext_in = 3'b111;
      repeat (3) tick();
      check_a("re_rise", 5'd1, 32'h3);
      check_pair("re_rise_other", 5'd2, 5'd3);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
